layer_compositor: RTL and testbench

- Parametrised successor to the fixed two-object pixel mixer; sits between the per-object display blocks and the VGA driver.
- Composites N sprite layers over a background by strict priority with a transparent colour key, through a registered 2-stage pipeline.
- Performs click hit-detection for slicing: on a mouse click it reports which layers are opaque under the cursor in the next full frame.
- Owns the click-toggled background enable.

---
 rtl/game_pkg.sv | 18 +
 rtl/priority_pick.sv | 23 ++
 rtl/layer_compositor.sv | 218 +++++++++++++++++++++
 tb/tb_layer_compositor.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and hit-detection state encoding for the display pipeline.
package game_pkg;

    localparam int COLOR_W = 12;
    localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;
    localparam int COL_W = 10;
    localparam int ROW_W = 9;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        HIT_IDLE   = 2'd0,
        HIT_ARMED  = 2'd1,
        HIT_SCAN   = 2'd2,
        HIT_REPORT = 2'd3
    } hit_state_e;

endpackage

// File: rtl/priority_pick.sv
// Lowest-index-set encoder: found flag plus index of the lowest set request bit.
module priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer priority compositor with colour-key transparency, click-toggled background
// and click-triggered per-layer hit detection at the cursor.
//
// state  | meaning
// IDLE   | no hit request pending
// ARMED  | cursor latched, waiting for the next frame start
// SCAN   | walking the frame looking for the cursor pixel
// REPORT | one-cycle hit_valid pulse with the captured mask
module layer_compositor #(
    parameter int N_LAYERS = 4,
    parameter int COLOR_W  = game_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] TRANSPARENT = game_pkg::TRANSPARENT,
    parameter int COL_W    = game_pkg::COL_W,
    parameter int ROW_W    = game_pkg::ROW_W,
    localparam int ID_W    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_LAYERS*COLOR_W-1:0]  layer_data,
    input  logic [N_LAYERS-1:0]          layer_en,
    input  logic [COLOR_W-1:0]           bg_data,
    input  logic                         pix_valid,
    input  logic [COL_W-1:0]             pix_col,
    input  logic [ROW_W-1:0]             pix_row,
    input  logic [COL_W-1:0]             cursor_x,
    input  logic [ROW_W-1:0]             cursor_y,
    input  logic                         click,
    output logic [COLOR_W-1:0]           out_data,
    output logic                         out_valid,
    output logic                         bg_en,
    output logic                         hit_valid,
    output logic [N_LAYERS-1:0]          hit_mask,
    output logic [ID_W-1:0]              hit_id,
    output logic                         hit_any
);
    import game_pkg::*;

    logic [N_LAYERS*COLOR_W-1:0] s1_data;
    logic [N_LAYERS-1:0]         s1_en;
    logic [COLOR_W-1:0]          s1_bg;
    logic                        s1_valid;
    logic [COL_W-1:0]            s1_col;
    logic [ROW_W-1:0]            s1_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_en    <= '0;
            s1_bg    <= '0;
            s1_valid <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_data  <= layer_data;
            s1_en    <= layer_en;
            s1_bg    <= bg_data;
            s1_valid <= pix_valid;
            s1_col   <= pix_col;
            s1_row   <= pix_row;
        end
    end

    logic [N_LAYERS-1:0] opaque;

    always_comb begin
        opaque = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            opaque[i] = s1_en[i] && (s1_data[i*COLOR_W +: COLOR_W] != TRANSPARENT);
        end
    end

    logic            px_found;
    logic [ID_W-1:0] px_idx;

    priority_pick #(.N(N_LAYERS), .IDX_W(ID_W)) u_pick_px (
        .req   (opaque),
        .found (px_found),
        .idx   (px_idx)
    );

    logic [COLOR_W-1:0] px_sel;
    logic [COLOR_W-1:0] px_mix;

    always_comb begin
        px_sel = TRANSPARENT;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (px_idx == ID_W'(i)) begin
                px_sel = s1_data[i*COLOR_W +: COLOR_W];
            end
        end
        if (!s1_valid) begin
            px_mix = '0;
        end else if (px_found) begin
            px_mix = px_sel;
        end else if (bg_en) begin
            px_mix = s1_bg;
        end else begin
            px_mix = TRANSPARENT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= px_mix;
            out_valid <= s1_valid;
        end
    end

    // click comes from the mouse domain; two flops before edge detection
    logic click_meta;
    logic click_sync;
    logic click_prev;
    logic click_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            click_meta <= 1'b0;
            click_sync <= 1'b0;
            click_prev <= 1'b0;
        end else begin
            click_meta <= click;
            click_sync <= click_meta;
            click_prev <= click_sync;
        end
    end

    assign click_rise = click_sync && !click_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            bg_en <= 1'b0;
        end else if (click_rise) begin
            bg_en <= !bg_en;
        end
    end

    hit_state_e       state;
    hit_state_e       state_next;
    logic [COL_W-1:0] cur_x;
    logic [ROW_W-1:0] cur_y;
    logic             latch_cursor;
    logic             capture_mask;
    logic             clear_mask;
    logic             frame_start;
    logic             cursor_hit;

    assign frame_start = s1_valid && (s1_col == '0) && (s1_row == '0);
    assign cursor_hit  = s1_valid && (s1_col == cur_x) && (s1_row == cur_y);

    always_comb begin
        state_next   = state;
        latch_cursor = 1'b0;
        capture_mask = 1'b0;
        clear_mask   = 1'b0;
        case (state)
            HIT_IDLE: begin
                if (click_rise) begin
                    latch_cursor = 1'b1;
                    state_next   = HIT_ARMED;
                end
            end
            HIT_ARMED: begin
                if (frame_start) begin
                    state_next = HIT_SCAN;
                end
            end
            HIT_SCAN: begin
                // a cursor at (0,0) coincides with frame start; the match wins
                if (cursor_hit) begin
                    capture_mask = 1'b1;
                    state_next   = HIT_REPORT;
                end else if (frame_start) begin
                    clear_mask = 1'b1;
                    state_next = HIT_REPORT;
                end
            end
            HIT_REPORT: begin
                state_next = HIT_IDLE;
            end
            default: begin
                state_next = HIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HIT_IDLE;
            cur_x    <= '0;
            cur_y    <= '0;
            hit_mask <= '0;
        end else begin
            state <= state_next;
            if (latch_cursor) begin
                cur_x <= cursor_x;
                cur_y <= cursor_y;
            end
            if (capture_mask) begin
                hit_mask <= opaque;
            end else if (clear_mask) begin
                hit_mask <= '0;
            end
        end
    end

    assign hit_valid = (state == HIT_REPORT);

    // hit_id/hit_any follow the held mask, so they hold between reports too
    priority_pick #(.N(N_LAYERS), .IDX_W(ID_W)) u_pick_hit (
        .req   (hit_mask),
        .found (hit_any),
        .idx   (hit_id)
    );

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: reference pixel model plus directed hit scenarios.
module tb_layer_compositor;

    localparam int N     = 4;
    localparam int CW    = 12;
    localparam int H_VIS = 104;
    localparam int H_TOT = 108;
    localparam int V_VIS = 52;
    localparam int V_TOT = 54;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*CW-1:0] layer_data;
    logic [N-1:0]  layer_en;
    logic [CW-1:0] bg_data;
    logic          pix_valid;
    logic [9:0]    pix_col;
    logic [8:0]    pix_row;
    logic [9:0]    cursor_x;
    logic [8:0]    cursor_y;
    logic          click;
    logic [CW-1:0] out_data;
    logic          out_valid;
    logic          bg_en;
    logic          hit_valid;
    logic [N-1:0]  hit_mask;
    logic [1:0]    hit_id;
    logic          hit_any;

    layer_compositor dut (
        .clk        (clk),
        .rst        (rst),
        .layer_data (layer_data),
        .layer_en   (layer_en),
        .bg_data    (bg_data),
        .pix_valid  (pix_valid),
        .pix_col    (pix_col),
        .pix_row    (pix_row),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .click      (click),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .bg_en      (bg_en),
        .hit_valid  (hit_valid),
        .hit_mask   (hit_mask),
        .hit_id     (hit_id),
        .hit_any    (hit_any)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] q_d[$];
    logic          q_v[$];
    logic          bg_model = 1'b0;

    int         step_idx  = 0;
    int         cur_frame = 0;
    int         hit_cnt   = 0;
    int         hit_pos   = -1;
    int         hit_frame = -1;
    logic [3:0] hit_mask_seen;
    logic [1:0] hit_id_seen;
    logic       hit_any_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Composite as described: first enabled non-key layer from index 0, else background/key.
    function automatic logic [CW-1:0] ref_pix(input logic [N*CW-1:0] d, input logic [N-1:0] en,
                                              input logic [CW-1:0] bg, input logic v, input logic bge);
        if (!v) return 12'h000;
        for (int i = 0; i < N; i++) begin
            if (en[i] && d[i*CW +: CW] != 12'h000) return d[i*CW +: CW];
        end
        return bge ? bg : 12'h000;
    endfunction

    task automatic step();
        if (rst) begin
            q_d.delete();
            q_v.delete();
            q_d.push_back(12'h000); q_v.push_back(1'b0);
            q_d.push_back(12'h000); q_v.push_back(1'b0);
            bg_model = 1'b0;
        end else begin
            q_d.push_back(ref_pix(layer_data, layer_en, bg_data, pix_valid, bg_model));
            q_v.push_back(pix_valid);
        end
        @(posedge clk);
        #1;
        if (q_d.size() == 2) begin
            check("out_data", 32'(out_data), 32'(q_d.pop_front()));
            check("out_valid", 32'(out_valid), 32'(q_v.pop_front()));
        end
        if (hit_valid === 1'b1) begin
            hit_cnt++;
            hit_pos       = step_idx;
            hit_frame     = cur_frame;
            hit_mask_seen = hit_mask;
            hit_id_seen   = hit_id;
            hit_any_seen  = hit_any;
        end
        step_idx++;
    endtask

    task automatic rand_layers();
        for (int i = 0; i < N; i++) begin
            layer_data[i*CW +: CW] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(1, 4095)) : 12'h000;
        end
        layer_en = 4'($urandom);
    endtask

    task automatic idle(input int n, input int click_len);
        if (click_len > 0) bg_model = ~bg_model;
        for (int k = 0; k < n; k++) begin
            pix_valid = 1'b0;
            pix_col   = 10'd0;
            pix_row   = 9'd0;
            rand_layers();
            click = (k < click_len);
            step();
        end
        click = 1'b0;
    endtask

    task automatic rand_pix(input int n);
        for (int k = 0; k < n; k++) begin
            rand_layers();
            pix_valid = ($urandom_range(0, 7) != 0);
            pix_col   = 10'($urandom_range(1, H_VIS - 1));
            pix_row   = 9'($urandom_range(1, V_VIS - 1));
            step();
        end
    endtask

    task automatic frame(input int click_at, input int rst_at, input int cx, input int cy,
                         input logic [N*CW-1:0] hd, input logic [N-1:0] hen);
        step_idx = 0;
        for (int r = 0; r < V_TOT; r++) begin
            for (int c = 0; c < H_TOT; c++) begin
                pix_col   = 10'(c);
                pix_row   = 9'(r);
                pix_valid = (c < H_VIS) && (r < V_VIS);
                rand_layers();
                bg_data = 12'h000;
                if (c == cx && r == cy) begin
                    layer_data = hd;
                    layer_en   = hen;
                end
                click = (click_at >= 0) && (step_idx >= click_at) && (step_idx < click_at + 6);
                if (step_idx == click_at) bg_model = ~bg_model;
                rst = (step_idx == rst_at);
                step();
            end
        end
        click = 1'b0;
        rst   = 1'b0;
        cur_frame++;
    endtask

    task automatic clear_hits();
        hit_cnt   = 0;
        hit_pos   = -1;
        hit_frame = -1;
        cur_frame = 0;
    endtask

    initial begin
        rst        = 1'b1;
        layer_data = '0;
        layer_en   = '0;
        bg_data    = 12'hABC;
        pix_valid  = 1'b0;
        pix_col    = '0;
        pix_row    = '0;
        cursor_x   = 10'd700;
        cursor_y   = 9'd10;
        click      = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_bg_en", 32'(bg_en), 32'd0);
        check("rst_hit_valid", 32'(hit_valid), 32'd0);
        check("rst_hit_mask", 32'(hit_mask), 32'd0);
        check("rst_hit_id", 32'(hit_id), 32'd0);
        check("rst_hit_any", 32'(hit_any), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        // priority and transparency
        pix_valid  = 1'b1;
        pix_col    = 10'd5;
        pix_row    = 9'd5;
        layer_data = {12'hF00, 12'h0F0, 12'h000, 12'h000};
        layer_en   = 4'b1111;
        step(); step();
        check("prio_l2", 32'(out_data), 32'h0F0);
        layer_en = 4'b1011;
        step(); step();
        check("prio_l3", 32'(out_data), 32'hF00);
        layer_data = '0;
        layer_en   = 4'b1111;
        step(); step();
        check("all_transparent", 32'(out_data), 32'h000);

        // background toggling
        idle(12, 6);
        check("bg_toggle_on", 32'(bg_en), 32'd1);
        bg_data    = 12'hABC;
        pix_valid  = 1'b1;
        layer_data = '0;
        step(); step();
        check("bg_shown", 32'(out_data), 32'hABC);
        for (int k = 0; k < 60; k++) begin
            bg_data = 12'($urandom);
            rand_pix(1);
        end
        idle(12, 6);
        check("bg_toggle_off", 32'(bg_en), 32'd0);
        bg_data    = 12'hABC;
        pix_valid  = 1'b1;
        layer_data = '0;
        step(); step();
        check("bg_hidden", 32'(out_data), 32'h000);
        rand_pix(60);
        idle(110, 100);
        check("bg_long_click", 32'(bg_en), 32'd1);
        idle(10, 0);
        check("bg_long_hold", 32'(bg_en), 32'd1);

        // back to a clean FSM before hit tests
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst2_bg_en", 32'(bg_en), 32'd0);

        // single opaque layer at the cursor
        clear_hits();
        cursor_x = 10'd100;
        cursor_y = 9'd50;
        idle(12, 6);
        frame(-1, -1, 100, 50, {12'h000, 12'h000, 12'h5A5, 12'h000}, 4'b1111);
        frame(-1, -1, 100, 50, {12'h000, 12'h000, 12'h5A5, 12'h000}, 4'b1111);
        check("l1_pulse_count", 32'(hit_cnt), 32'd1);
        check("l1_pulse_frame", 32'(hit_frame), 32'd0);
        check("l1_pulse_pos", 32'(hit_pos), 32'(50 * H_TOT + 100 + 1));
        check("l1_mask", 32'(hit_mask_seen), 32'b0010);
        check("l1_id", 32'(hit_id_seen), 32'd1);
        check("l1_any", 32'(hit_any_seen), 32'd1);
        check("l1_mask_held", 32'(hit_mask), 32'b0010);

        // overlapping layers, disabled layer ignored
        clear_hits();
        cursor_x = 10'd57;
        cursor_y = 9'd33;
        idle(12, 6);
        frame(-1, -1, 57, 33, {12'h123, 12'h000, 12'h777, 12'hF0F}, 4'b1101);
        check("ovl_pulse_count", 32'(hit_cnt), 32'd1);
        check("ovl_pulse_pos", 32'(hit_pos), 32'(33 * H_TOT + 57 + 1));
        check("ovl_mask", 32'(hit_mask_seen), 32'b1001);
        check("ovl_id", 32'(hit_id_seen), 32'd0);
        check("ovl_id_held", 32'(hit_id), 32'd0);

        // off-screen cursor with a second click while scanning
        clear_hits();
        cursor_x = 10'd700;
        cursor_y = 9'd10;
        idle(12, 6);
        check("off_bg_on", 32'(bg_en), 32'd1);
        cursor_x = 10'd20;
        cursor_y = 9'd5;
        frame(1000, -1, 700, 10, '0, 4'b0000);
        check("off_bg_second", 32'(bg_en), 32'd0);
        frame(-1, -1, 700, 10, '0, 4'b0000);
        check("off_pulse_count", 32'(hit_cnt), 32'd1);
        check("off_pulse_frame", 32'(hit_frame), 32'd1);
        check("off_pulse_pos", 32'(hit_pos), 32'd1);
        check("off_mask", 32'(hit_mask_seen), 32'd0);
        check("off_any", 32'(hit_any_seen), 32'd0);

        // reset while scanning, then a fresh click
        clear_hits();
        cursor_x = 10'd100;
        cursor_y = 9'd50;
        idle(12, 6);
        frame(-1, 3000, 100, 50, {12'h000, 12'h000, 12'h5A5, 12'h000}, 4'b1111);
        frame(-1, -1, 100, 50, {12'h000, 12'h000, 12'h5A5, 12'h000}, 4'b1111);
        check("rst_scan_pulses", 32'(hit_cnt), 32'd0);
        check("rst_scan_bg_en", 32'(bg_en), 32'd0);
        check("rst_scan_any", 32'(hit_any), 32'd0);
        clear_hits();
        cursor_x = 10'd30;
        cursor_y = 9'd20;
        idle(12, 6);
        frame(-1, -1, 30, 20, {12'h000, 12'h9C3, 12'h000, 12'h000}, 4'b1111);
        check("after_rst_count", 32'(hit_cnt), 32'd1);
        check("after_rst_pos", 32'(hit_pos), 32'(20 * H_TOT + 30 + 1));
        check("after_rst_mask", 32'(hit_mask_seen), 32'b0100);
        check("after_rst_id", 32'(hit_id_seen), 32'd2);
        check("after_rst_bg_en", 32'(bg_en), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
